alu_instr_encoder: RTL and testbench

- Inverse of the pipeline's ALU control decode path: accepts an ALU operation code (3-bit ALUControl encoding) plus register indices and emits the corresponding 32-bit RV32 R-type instruction word.
- Feeds instruction-memory preload and self-test stimulus generators.
- Valid/ready on both sides, with a 2-entry output buffer, an emitted-word counter and an illegal-code error path.

---
 rtl/alu_enc_pkg.sv | 47 ++++
 rtl/alu_instr_encoder_fifo.sv | 63 ++++++
 rtl/alu_instr_encoder.sv | 94 +++++++++
 tb/tb_alu_instr_encoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_enc_pkg.sv
// alu_enc_pkg: shared constants and the ALU-code decode helper used by the
// RV32 R-type/I-type instruction encoder.
//   - ALU_ADD..ALU_NAND : 3-bit ALU control codes (3'b111 is illegal)
//   - OP_RTYPE/OP_ITYPE : RV32 major opcodes
//   - FUNCT7_SUB        : funct7 value selecting SUB
//   - alu_decode()      : code -> {legal, funct3, funct7}
package alu_enc_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_NAND = 3'b110;
  localparam logic [2:0] ALU_ILL  = 3'b111;

  localparam logic [6:0] OP_RTYPE    = 7'b0110011;
  localparam logic [6:0] OP_ITYPE    = 7'b0010011;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;

  typedef struct packed {
    logic       legal;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [2:0] code);
    alu_dec_t d;
    d.legal  = 1'b1;
    d.funct3 = 3'b000;
    d.funct7 = FUNCT7_BASE;
    case (code)
      ALU_ADD:  d.funct3 = 3'b000;
      ALU_SUB:  begin d.funct3 = 3'b000; d.funct7 = FUNCT7_SUB; end
      ALU_AND:  d.funct3 = 3'b111;
      ALU_OR:   d.funct3 = 3'b110;
      ALU_XOR:  d.funct3 = 3'b100;
      ALU_NOR:  d.funct3 = 3'b101;
      ALU_NAND: d.funct3 = 3'b010;
      default:  d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_instr_encoder_fifo.sv
// instr_fifo: DEPTH x DATA_W synchronous FIFO with occupancy count.
//   clk, rst_n      : clock, async active-low reset (control state only)
//   push, wdata     : write request (ignored when full)
//   pop             : read request (ignored when empty)
//   rdata           : raw head entry (meaningful only when !empty)
//   full, empty     : status derived from the count register
//   count           : occupancy, width clog2(DEPTH)+1
module instr_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // storage stage: data array carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: turns an ALU control code plus register indices into a
// 32-bit RV32 R-type instruction word, buffered in a DEPTH-entry FIFO.
//   in_valid/in_ready        : request handshake (in_ready = !full)
//   alu_ctrl, rd, rs1, rs2   : operation code and register indices
//   out_valid/out_ready      : instruction word handshake
//   instr                    : head word, 0 while the buffer is empty
//   err_pulse                : one-cycle pulse after an accepted illegal code
//   instr_count              : delivered-word counter (wraps)
// Optional macro ALU_ENC_IMM_EN adds is_imm/imm and I-type encoding;
// SUB with is_imm=1 is rejected as illegal.
module alu_instr_encoder
  import alu_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
`ifdef ALU_ENC_IMM_EN
  input  logic             is_imm,
  input  logic [11:0]      imm,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err_pulse,
  output logic [CNT_W-1:0] instr_count
);

  alu_dec_t              dec;
  logic                  legal;
  logic [31:0]           word;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [31:0]           head;
  logic [$clog2(DEPTH):0] occ;

  // encode stage: combinational word formation from the request fields
  always_comb begin
    dec   = alu_decode(alu_ctrl);
    legal = dec.legal;
    word  = {dec.funct7, rs2, rs1, dec.funct3, rd, OP_RTYPE};
`ifdef ALU_ENC_IMM_EN
    if (is_imm) begin
      word = {imm, rs1, dec.funct3, rd, OP_ITYPE};
      if (alu_ctrl == ALU_SUB) legal = 1'b0;
    end
`endif
  end

  assign in_ready  = ~full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // masking the raw head keeps instr at zero whenever nothing is buffered
  assign instr     = empty ? 32'h0 : head;

  instr_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // status stage: error pulse and delivered-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse   <= 1'b0;
      instr_count <= '0;
    end else begin
      err_pulse <= accept & ~legal;
      if (pop) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
module tb_alu_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       alu_ctrl = 3'd0;
  logic [4:0]       rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic             is_imm = 1'b0;
  logic [11:0]      imm = 12'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      instr;
  logic             err_pulse;
  logic [CNT_W-1:0] instr_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .rd(rd), .rs1(rs1), .rs2(rs2),
`ifdef ALU_ENC_IMM_EN
    .is_imm(is_imm), .imm(imm),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err_pulse(err_pulse), .instr_count(instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the instruction-format rules.
  function automatic bit model_legal(input logic [2:0] c, input logic im);
    if (c == 3'd7) return 1'b0;
`ifdef ALU_ENC_IMM_EN
    if (im && c == 3'd1) return 1'b0;
`else
    if (im && 1'b0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_word(input logic [2:0] c, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic im, input logic [11:0] iv);
    logic [2:0] f3;
    logic [6:0] f7;
    f7 = 7'd0;
    case (c)
      3'd0: f3 = 3'd0;
      3'd1: begin f3 = 3'd0; f7 = 7'h20; end
      3'd2: f3 = 3'd7;
      3'd3: f3 = 3'd6;
      3'd4: f3 = 3'd4;
      3'd5: f3 = 3'd5;
      default: f3 = 3'd2;
    endcase
`ifdef ALU_ENC_IMM_EN
    if (im) return (32'(iv) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
`else
    if (im && iv == 12'hFFF && 1'b0) return 32'h0;
`endif
    return (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h33;
  endfunction

  // Behavioural model: a queue of pending words, a delivered counter, an error flag.
  logic [31:0]      mq[$];
  logic             m_err = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      bit acc, pp;
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() != 0) && out_ready;
      m_err = acc && !model_legal(alu_ctrl, is_imm);
      if (pp) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (acc && model_legal(alu_ctrl, is_imm))
        mq.push_back(model_word(alu_ctrl, rd, rs1, rs2, is_imm, imm));
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("instr", instr, (mq.size() != 0) ? mq[0] : 32'h0);
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
  end

  // Called at a negedge; returns at the negedge after the request was taken.
  task automatic send(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2);
    int budget = 0;
    alu_ctrl = c; rd = d; rs1 = s1; rs2 = s2; in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stuck low");
    end
    @(negedge clk);
  endtask

  logic [CNT_W-1:0] base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    chk("model_add", model_word(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0), 32'h003100B3);
    chk("model_sub", model_word(3'd1, 5'd5, 5'd6, 5'd7, 1'b0, 12'd0), 32'h407302B3);
    chk("model_nand", model_word(3'd6, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0), 32'h003120B3);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err_pulse}, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single ADD, 1-cycle latency
    out_ready = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_instr", instr, 32'h003100B3);
    @(negedge clk);
    chk("add_count", 32'(instr_count), 32'd1);

    send(3'd1, 5'd5, 5'd6, 5'd7);
    in_valid = 1'b0;
    chk("sub_instr", instr, 32'h407302B3);
    @(negedge clk);
    send(3'd6, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b0;
    chk("nand_instr", instr, 32'h003120B3);
    @(negedge clk);
    chk("count3", 32'(instr_count), 32'd3);

    // backpressure: fill, hold third request, then drain in order
    base = instr_count;
    out_ready = 1'b0;
    send(3'd2, 5'd1, 5'd2, 5'd3);
    send(3'd3, 5'd1, 5'd2, 5'd3);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", instr, 32'h003170B3);
    alu_ctrl = 3'd4; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_instr", instr, 32'h003170B3);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_w2", instr, 32'h003160B3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_w3", instr, 32'h003140B3);
    @(negedge clk);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_count", 32'(instr_count - base), 32'd3);

    // illegal code followed immediately by ADD
    base = instr_count;
    send(3'd7, 5'd1, 5'd2, 5'd3);
    chk("ill_err", {31'd0, err_pulse}, 32'd1);
    chk("ill_novalid", {31'd0, out_valid}, 32'd0);
    chk("ill_count", 32'(instr_count), 32'(base));
    send(3'd0, 5'd4, 5'd5, 5'd6);
    in_valid = 1'b0;
    chk("ill_err_drop", {31'd0, err_pulse}, 32'd0);
    chk("post_ill_instr", instr, 32'h00628233);
    @(negedge clk);

`ifdef ALU_ENC_IMM_EN
    is_imm = 1'b1; imm = 12'h005;
    send(3'd0, 5'd1, 5'd0, 5'd9);
    in_valid = 1'b0;
    chk("imm_add", instr, 32'h00500093);
    @(negedge clk);
    send(3'd1, 5'd1, 5'd0, 5'd9);
    in_valid = 1'b0;
    chk("imm_sub_err", {31'd0, err_pulse}, 32'd1);
    chk("imm_sub_noval", {31'd0, out_valid}, 32'd0);
    is_imm = 1'b0; imm = 12'd0;
    @(negedge clk);
`endif

    // asynchronous reset with a full buffer
    out_ready = 1'b0;
    send(3'd4, 5'd9, 5'd8, 5'd7);
    send(3'd5, 5'd9, 5'd8, 5'd7);
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
